timer_ctrl_master: RTL and testbench

Avalon-MM master that drives the interval timer's 16-bit register port from the other end. It programs period and control, and services the timer interrupt by clearing status and counting timeouts. It can also capture a live counter snapshot. It sits between fabric logic that needs periodic ticks and a timer slave, so no CPU is involved in timer servicing.

---
 rtl/timer_ctrl_master.sv | 163 ++++++++++++++++
 tb/tb_timer_ctrl_master.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl_master.sv
// timer_ctrl_master: Avalon-MM master that programs an interval timer and services its interrupt.
// Optional live-counter snapshot path is built when TIMER_CTRL_MASTER_SNAPSHOT_EN is defined.
module timer_ctrl_master (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cfg_period,
    input  logic        cfg_continuous,
    input  logic        cmd_start,
    input  logic        cmd_stop,
    input  logic        cmd_snap,
    output logic        cmd_ready,
    output logic        busy,
    output logic        cfg_err,
    output logic        tick,
    output logic [15:0] tick_count,
    output logic [31:0] snap_value,
    output logic        snap_valid,
    output logic [2:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [15:0] m_writedata,
    input  logic [15:0] m_readdata,
    input  logic        irq
);
    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR, STOP
`ifdef TIMER_CTRL_MASTER_SNAPSHOT_EN
        , SNAP_W, SNAP_RL, SNAP_RH, SNAP_DONE
`endif
    } state_t;

    state_t      state, nxt;
    logic [31:0] period;
    logic        cont;
    logic        stop_pend;
    logic        stop_req;
    logic        start_ok;

    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign start_ok  = cmd_ready && cmd_start && cfg_period != 32'd0;
    assign stop_req  = stop_pend || cmd_stop;

    // Next-state decode and one-cycle bus access driven from the current state
    always_comb begin
        nxt          = state;
        m_chipselect = 1'b0;
        m_write_n    = 1'b1;
        m_address    = 3'd0;
        m_writedata  = 16'd0;
        tick         = 1'b0;
        case (state)
            IDLE: nxt = start_ok ? WR_PL : IDLE;
            WR_PL: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_address    = 3'd2;
                m_writedata  = period[15:0];
                nxt          = WR_PH;
            end
            WR_PH: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_address    = 3'd3;
                m_writedata  = period[31:16];
                nxt          = WR_CTRL;
            end
            WR_CTRL: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_address    = 3'd1;
                m_writedata  = cont ? 16'h0007 : 16'h0005;
                nxt          = RUN;
            end
            RUN: begin
                if (irq) nxt = CLR;
                else if (stop_req) nxt = STOP;
`ifdef TIMER_CTRL_MASTER_SNAPSHOT_EN
                else if (cmd_snap) nxt = SNAP_W;
`endif
            end
            CLR: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                tick         = 1'b1;
                nxt          = cont ? RUN : IDLE;
            end
            STOP: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_address    = 3'd1;
                m_writedata  = 16'h0008;
                nxt          = IDLE;
            end
`ifdef TIMER_CTRL_MASTER_SNAPSHOT_EN
            SNAP_W: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_address    = 3'd4;
                nxt          = SNAP_RL;
            end
            SNAP_RL: begin
                m_chipselect = 1'b1;
                m_address    = 3'd4;
                nxt          = SNAP_RH;
            end
            SNAP_RH: begin
                m_chipselect = 1'b1;
                m_address    = 3'd5;
                nxt          = SNAP_DONE;
            end
            SNAP_DONE: nxt = RUN;
`endif
            default: nxt = IDLE;
        endcase
    end

    // State, latched configuration, pending stop, error pulse and timeout counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            period     <= 32'd0;
            cont       <= 1'b0;
            stop_pend  <= 1'b0;
            cfg_err    <= 1'b0;
            tick_count <= 16'd0;
        end else begin
            state     <= nxt;
            cfg_err   <= cmd_ready && cmd_start && cfg_period == 32'd0;
            stop_pend <= (state == IDLE || state == STOP) ? 1'b0 : stop_req;
            if (start_ok) begin
                period     <= cfg_period;
                cont       <= cfg_continuous;
                tick_count <= 16'd0;
            end else if (state == CLR) begin
                tick_count <= tick_count + 16'd1;
            end
        end
    end

`ifdef TIMER_CTRL_MASTER_SNAPSHOT_EN
    logic [15:0] snap_lo;

    // Assemble the snapshot from the two registered read beats
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_lo    <= 16'd0;
            snap_value <= 32'd0;
            snap_valid <= 1'b0;
        end else begin
            if (state == SNAP_RH) snap_lo <= m_readdata;
            if (state == SNAP_DONE) snap_value <= {m_readdata, snap_lo};
            snap_valid <= state == SNAP_DONE;
        end
    end
`else
    logic unused;

    assign unused     = ^{m_readdata, cmd_snap};
    assign snap_value = 32'd0;
    assign snap_valid = 1'b0;
`endif
endmodule

// File: tb/tb_timer_ctrl_master.sv
// tb_timer_ctrl_master: scoreboard bench for timer_ctrl_master against a behavioural timer slave.
module tb_timer_ctrl_master;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] cfg_period;
    logic        cfg_continuous;
    logic        cmd_start, cmd_stop, cmd_snap;
    logic        cmd_ready, busy, cfg_err, tick, snap_valid;
    logic [15:0] tick_count;
    logic [31:0] snap_value;
    logic [2:0]  m_address;
    logic        m_chipselect, m_write_n;
    logic [15:0] m_writedata, m_readdata;
    logic        irq;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [19:0] exp_q[$];

    logic        mrst_n, ld_en, inj_to;
    logic [31:0] ld_val;
    logic        t_run, t_cont, t_ito, t_to;
    logic [31:0] t_cnt, t_per, t_snap;

    timer_ctrl_master dut (
        .clk(clk), .reset_n(reset_n), .cfg_period(cfg_period), .cfg_continuous(cfg_continuous),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_snap(cmd_snap), .cmd_ready(cmd_ready),
        .busy(busy), .cfg_err(cfg_err), .tick(tick), .tick_count(tick_count),
        .snap_value(snap_value), .snap_valid(snap_valid), .m_address(m_address),
        .m_chipselect(m_chipselect), .m_write_n(m_write_n), .m_writedata(m_writedata),
        .m_readdata(m_readdata), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign irq = t_to & t_ito;

    // Interval timer slave: control bits ITO=0, CONT=1, START=2, STOP=3; readdata registered
    always @(posedge clk or negedge mrst_n) begin
        if (!mrst_n) begin
            t_run <= 0; t_cont <= 0; t_ito <= 0; t_to <= 0;
            t_cnt <= 0; t_per <= 0; t_snap <= 0; m_readdata <= 0;
        end else begin
            m_readdata <= (m_chipselect && m_write_n) ?
                          (m_address == 3'd4 ? t_snap[15:0] : m_address == 3'd5 ? t_snap[31:16] : 16'd0) : 16'd0;
            if (t_run) begin
                if (t_cnt == 0) begin
                    t_to  <= 1;
                    t_cnt <= t_per;
                    if (!t_cont) t_run <= 0;
                end else t_cnt <= t_cnt - 1;
            end
            if (inj_to) t_to <= 1;
            if (ld_en) begin t_cnt <= ld_val; t_run <= 0; end
            if (m_chipselect && !m_write_n) begin
                case (m_address)
                    3'd0: t_to <= 0;
                    3'd1: begin
                        t_ito  <= m_writedata[0];
                        t_cont <= m_writedata[1];
                        if (m_writedata[2]) begin t_run <= 1; t_cnt <= t_per; end
                        if (m_writedata[3]) t_run <= 0;
                    end
                    3'd2: t_per[15:0] <= m_writedata;
                    3'd3: t_per[31:16] <= m_writedata;
                    3'd4: t_snap <= t_cnt;
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] acc(input logic [2:0] a, input logic wn, input logic [15:0] d);
        return {a, wn, d};
    endfunction

    // Every bus access is popped against the scoreboard; idle cycles must show idle values
    always @(negedge clk) begin
        if (m_chipselect) begin
            if (exp_q.size() == 0) check("bus_unexpected", {12'd0, m_address, m_write_n, m_writedata}, 32'hFFFF_FFFF);
            else check("bus_access", {12'd0, m_address, m_write_n, m_writedata}, {12'd0, exp_q.pop_front()});
        end else check("bus_idle", {12'd0, m_address, m_write_n, m_writedata}, {12'd0, 3'd0, 1'b1, 16'd0});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_timer(input logic [31:0] p, input logic c);
        exp_q.push_back(acc(3'd2, 1'b0, p[15:0]));
        exp_q.push_back(acc(3'd3, 1'b0, p[31:16]));
        exp_q.push_back(acc(3'd1, 1'b0, c ? 16'h0007 : 16'h0005));
        cfg_period = p;
        cfg_continuous = c;
        cmd_start = 1;
        step();
        cmd_start = 0;
    endtask

    task automatic wait_tick(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (tick) begin at = cyc; return; end
        end
        check("tick_timeout", {31'd0, tick}, 32'd1);
    endtask

    task automatic wait_ready(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (cmd_ready) return;
            step();
        end
        check("ready_timeout", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic stop_timer();
        exp_q.push_back(acc(3'd1, 1'b0, 16'h0008));
        cmd_stop = 1;
        step();
        cmd_stop = 0;
        wait_ready(10);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, last;
        reset_n = 0; mrst_n = 0; cfg_period = 0; cfg_continuous = 0;
        cmd_start = 0; cmd_stop = 0; cmd_snap = 0; ld_en = 0; ld_val = 0; inj_to = 0;
        #12;
        check("rst_ready", {31'd0, cmd_ready}, 1);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_cfg_err", {31'd0, cfg_err}, 0);
        check("rst_tick", {31'd0, tick}, 0);
        check("rst_snap_valid", {31'd0, snap_valid}, 0);
        check("rst_tick_count", {16'd0, tick_count}, 0);
        check("rst_snap_value", snap_value, 0);
        @(posedge clk); #1;
        reset_n = 1; mrst_n = 1;
        step();

        // programming sequence: three consecutive writes
        start_timer(32'h0001_0003, 1);
        check("prog_busy", {31'd0, busy}, 1);
        check("prog_ready", {31'd0, cmd_ready}, 0);
        step(); step(); step();
        check("prog_done", exp_q.size(), 0);
        stop_timer();

        // periodic run, period 9: tick every 10 cycles
        start_timer(32'd9, 1);
        for (int k = 0; k < 5; k++) exp_q.push_back(acc(3'd0, 1'b0, 16'h0000));
        last = 0;
        for (int k = 0; k < 5; k++) begin
            wait_tick(60, t);
            if (k > 0) check("tick_period", t - last, 10);
            last = t;
        end
        step();
        check("periodic_count", {16'd0, tick_count}, 5);
        stop_timer();
        check("periodic_q", exp_q.size(), 0);

        // one-shot, period 4: exactly one tick then idle
        start_timer(32'd4, 0);
        exp_q.push_back(acc(3'd0, 1'b0, 16'h0000));
        wait_tick(40, t);
        step();
        check("oneshot_ready", {31'd0, cmd_ready}, 1);
        check("oneshot_count", {16'd0, tick_count}, 1);
        repeat (20) step();
        check("oneshot_q", exp_q.size(), 0);

        // stop pending from WR_PH with irq in first RUN cycle: CLR then STOP
        start_timer(32'd9, 1);
        exp_q.push_back(acc(3'd0, 1'b0, 16'h0000));
        exp_q.push_back(acc(3'd1, 1'b0, 16'h0008));
        step();
        cmd_stop = 1;
        step();
        cmd_stop = 0;
        inj_to = 1;
        step();
        inj_to = 0;
        check("pend_run_no_tick", {31'd0, tick}, 0);
        step();
        check("pend_clr_tick", {31'd0, tick}, 1);
        step();
        check("pend_count", {16'd0, tick_count}, 1);
        wait_ready(10);
        check("pend_q", exp_q.size(), 0);
        check("pend_count_idle", {16'd0, tick_count}, 1);

        // rejected start and ignored commands
        cfg_period = 0;
        cmd_start = 1;
        step();
        cmd_start = 0;
        check("cfg_err_pulse", {31'd0, cfg_err}, 1);
        check("cfg_err_ready", {31'd0, cmd_ready}, 1);
        step();
        check("cfg_err_clear", {31'd0, cfg_err}, 0);
        start_timer(32'd9, 1);
        cfg_period = 32'd5;
        cmd_start = 1;
        step();
        cmd_start = 0;
        step(); step();
        check("restart_ignored_count", {16'd0, tick_count}, 0);
`ifndef TIMER_CTRL_MASTER_SNAPSHOT_EN
        cmd_snap = 1;
        step();
        cmd_snap = 0;
        for (int k = 0; k < 5; k++) begin
            check("snap_valid_tied", {31'd0, snap_valid}, 0);
            step();
        end
        check("snap_value_tied", snap_value, 0);
`endif
        stop_timer();
        cmd_stop = 1;
        cmd_snap = 1;
        step();
        cmd_stop = 0;
        cmd_snap = 0;
        repeat (5) step();
        check("idle_cmds_ignored", exp_q.size(), 0);
        check("idle_ready", {31'd0, cmd_ready}, 1);

`ifdef TIMER_CTRL_MASTER_SNAPSHOT_EN
        // snapshot of a frozen counter with an irq raised mid-snapshot
        start_timer(32'h0010_0000, 1);
        step(); step(); step();
        ld_en = 1;
        ld_val = 32'h0002_0010;
        step();
        ld_en = 0;
        exp_q.push_back(acc(3'd4, 1'b0, 16'h0000));
        exp_q.push_back(acc(3'd4, 1'b1, 16'h0000));
        exp_q.push_back(acc(3'd5, 1'b1, 16'h0000));
        exp_q.push_back(acc(3'd0, 1'b0, 16'h0000));
        cmd_snap = 1;
        step();
        step();
        cmd_snap = 0;
        inj_to = 1;
        step();
        inj_to = 0;
        check("snap_valid_early", {31'd0, snap_valid}, 0);
        step();
        check("snap_valid_done", {31'd0, snap_valid}, 0);
        step();
        check("snap_valid", {31'd0, snap_valid}, 1);
        check("snap_value", snap_value, 32'h0002_0010);
        step();
        check("snap_irq_tick", {31'd0, tick}, 1);
        step();
        check("snap_valid_pulse", {31'd0, snap_valid}, 0);
        check("snap_tick_count", {16'd0, tick_count}, 1);
        stop_timer();
        check("snap_q", exp_q.size(), 0);
`endif

        // asynchronous reset mid-run
        start_timer(32'd9, 1);
        exp_q.push_back(acc(3'd0, 1'b0, 16'h0000));
        wait_tick(40, t);
        step();
        check("mid_count", {16'd0, tick_count}, 1);
        reset_n = 0;
        #2;
        check("mid_rst_ready", {31'd0, cmd_ready}, 1);
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_count", {16'd0, tick_count}, 0);
        step();
        reset_n = 1;
        repeat (20) step();
        check("mid_rst_idle", {31'd0, cmd_ready}, 1);
        check("final_q", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
